// File: rtl/test_status_pkg.sv
// test_status_pkg: shared types and constants for the test status reporter.
package test_status_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, PASS, FAIL} state_t;
  typedef enum logic [1:0] {NONE, EXIT_CODE, WATCHDOG} fail_reason_t;
  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h8000_1000;
endpackage

// File: rtl/test_status_reporter_if.sv
// test_status_reporter_if: simple write port from the bus bridge into the reporter.
interface test_status_reporter_if #(
  parameter int XLEN = 64,
  parameter int ADDR_W = 32
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [XLEN-1:0]   wr_data;
  modport master (output wr_valid, wr_addr, wr_data, input wr_ready);
  modport slave (input wr_valid, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/status_watchdog.sv
// status_watchdog: no-activity counter pulsing expire after LIMIT un-kicked enabled cycles.
module status_watchdog #(
  parameter int LIMIT = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic kick,
  output logic expire
);
  localparam int W = LIMIT > 0 ? $clog2(LIMIT + 1) : 1;
  localparam logic [W-1:0] TERM = W'(LIMIT - 1);
  logic [W-1:0] count;
  // Saturates at the terminal count so it can never wrap; LIMIT=0 masks the pulse entirely.
  always_ff @(posedge clock or negedge reset)
    if (!reset) count <= '0;
    else if (kick) count <= '0;
    else if (enable && count != TERM) count <= count + 1'b1;
  assign expire = (LIMIT != 0) && enable && !kick && count == TERM;
endmodule

// File: rtl/test_status_reporter.sv
// test_status_reporter: decodes TOHOST exit writes and a watchdog into a registered pass/fail verdict.
module test_status_reporter
  import test_status_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(TOHOST_ADDR_DEFAULT),
  parameter int DRAIN_CYCLES = 16,
  parameter int WATCHDOG_CYCLES = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  test_status_reporter_if.slave  wr,
  output logic                   io_success,
  output logic                   io_failure,
  output logic [XLEN-2:0]        exit_code,
  output logic [1:0]             fail_reason,
  output logic                   busy
);
  state_t          state_q, state_d;
  fail_reason_t    reason_q, reason_d;
  logic [7:0]      drain_q, drain_d;
  logic [XLEN-2:0] code_q, code_d;
  logic            hit, expire, nonzero;
  assign wr.wr_ready = 1'b1;
  assign hit = wr.wr_valid && wr.wr_addr == TOHOST_ADDR;
  assign nonzero = |wr.wr_data[XLEN-1:1];
  status_watchdog #(.LIMIT(WATCHDOG_CYCLES)) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .enable (state_q == RUN),
    .kick   (hit && state_q == RUN),
    .expire (expire)
  );
  always_comb begin
    state_d = state_q;
    reason_d = reason_q;
    drain_d = drain_q;
    code_d = code_q;
    if (state_q == RUN && hit && wr.wr_data[0]) begin
      code_d = wr.wr_data[XLEN-1:1];
      reason_d = nonzero ? EXIT_CODE : NONE;
      state_d = DRAIN_CYCLES > 0 ? DRAIN : (nonzero ? FAIL : PASS);
    end else if (state_q == RUN && expire) begin
      code_d = '0;
      reason_d = WATCHDOG;
      state_d = FAIL;
    end else if (state_q == DRAIN) begin
      drain_d = drain_q + 8'd1;
      if (drain_q == 8'(DRAIN_CYCLES - 1)) state_d = reason_q == NONE ? PASS : FAIL;
    end
  end
  // Verdict and busy flags are re-registered off the state, adding the one-cycle output stage.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= RUN;
      reason_q <= NONE;
      drain_q <= '0;
      code_q <= '0;
      io_success <= 1'b0;
      io_failure <= 1'b0;
      busy <= 1'b1;
    end else begin
      state_q <= state_d;
      reason_q <= reason_d;
      drain_q <= drain_d;
      code_q <= code_d;
      io_success <= state_q == PASS;
      io_failure <= state_q == FAIL;
      busy <= state_q == RUN || state_q == DRAIN;
    end
  assign exit_code = code_q;
  assign fail_reason = reason_q;
endmodule

// File: tb/tb_test_status_reporter.sv
// tb_test_status_reporter: randomized scoreboard bench for two reporter configurations.
module tb_test_status_reporter;
  localparam logic [31:0] TH = 32'h8000_1000;
  localparam int DA = 16, WA = 100, DB = 0, WB = 0;
  typedef struct {
    int          at;
    bit          ok;
    logic [62:0] code;
    logic [1:0]  reason;
  } vexp_t;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;
  test_status_reporter_if bus_a ();
  test_status_reporter_if bus_b ();
  logic        succ [2];
  logic        fail [2];
  logic        busy [2];
  logic [62:0] code [2];
  logic [1:0]  reason [2];
  test_status_reporter #(.DRAIN_CYCLES(DA), .WATCHDOG_CYCLES(WA)) dut_a (
    .clock(clock), .reset(reset), .wr(bus_a), .io_success(succ[0]), .io_failure(fail[0]),
    .exit_code(code[0]), .fail_reason(reason[0]), .busy(busy[0]));
  test_status_reporter #(.DRAIN_CYCLES(DB), .WATCHDOG_CYCLES(WB)) dut_b (
    .clock(clock), .reset(reset), .wr(bus_b), .io_success(succ[1]), .io_failure(fail[1]),
    .exit_code(code[1]), .fail_reason(reason[1]), .busy(busy[1]));
  int checks = 0, failures = 0, cyc = 0;
  vexp_t sb [2][$];
  int m_vat [2], m_kick [2];
  logic [62:0] m_code [2];
  logic [1:0] m_reason [2];
  int dr [2] = '{DA, DB};
  int wd [2] = '{WA, WB};
  bit prev [2];
  always @(posedge clock or negedge reset)
    if (!reset) cyc <= 0;
    else cyc <= cyc + 1;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  // Monitor: every rising verdict pops the scoreboard and must match time, kind and latched code.
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      vexp_t x;
      if (reset) begin
        if ((succ[i] | fail[i]) && !prev[i]) begin
          if (sb[i].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL verdict%0d unexpected at edge %0d", i, cyc);
          end else begin
            x = sb[i].pop_front();
            chk($sformatf("v_edge%0d", i), 64'(cyc), 64'(x.at));
            chk($sformatf("v_succ%0d", i), 64'(succ[i]), 64'(x.ok));
            chk($sformatf("v_fail%0d", i), 64'(fail[i]), 64'(!x.ok));
            chk($sformatf("v_code%0d", i), 64'(code[i]), 64'(x.code));
            chk($sformatf("v_reason%0d", i), 64'(reason[i]), 64'(x.reason));
          end
        end
        chk($sformatf("exclusive%0d", i), 64'(succ[i] & fail[i]), 64'd0);
        prev[i] = succ[i] | fail[i];
      end else prev[i] = 1'b0;
    end
  end
  task automatic drive(bit v, logic [31:0] a, logic [63:0] d);
    bus_a.wr_valid = v; bus_a.wr_addr = a; bus_a.wr_data = d;
    bus_b.wr_valid = v; bus_b.wr_addr = a; bus_b.wr_data = d;
  endtask
  // Reference: verdict time is the exit edge plus drain plus one, or last kick plus limit plus one.
  task automatic model(bit v, logic [31:0] a, logic [63:0] d);
    vexp_t x;
    for (int i = 0; i < 2; i++) begin
      if (m_vat[i] != 0) continue;
      if (v && a == TH && d[0]) begin
        m_code[i] = d[63:1];
        m_reason[i] = d[63:1] != 0 ? 2'd1 : 2'd0;
        m_vat[i] = cyc + 1 + dr[i];
      end else if (v && a == TH) m_kick[i] = cyc;
      else if (wd[i] > 0 && cyc - m_kick[i] == wd[i]) begin
        m_code[i] = '0;
        m_reason[i] = 2'd2;
        m_vat[i] = cyc + 1;
      end
      if (m_vat[i] != 0) begin
        x.at = m_vat[i]; x.ok = m_reason[i] == 0; x.code = m_code[i]; x.reason = m_reason[i];
        sb[i].push_back(x);
      end
    end
  endtask
  task automatic check_now();
    bit done;
    for (int i = 0; i < 2; i++) begin
      done = m_vat[i] != 0 && cyc >= m_vat[i];
      chk($sformatf("busy%0d", i), 64'(busy[i]), 64'(!done));
      chk($sformatf("success%0d", i), 64'(succ[i]), 64'(done && m_reason[i] == 0));
      chk($sformatf("failure%0d", i), 64'(fail[i]), 64'(done && m_reason[i] != 0));
      chk($sformatf("exit_code%0d", i), 64'(code[i]), 64'(m_code[i]));
      chk($sformatf("fail_reason%0d", i), 64'(reason[i]), 64'(m_reason[i]));
    end
    chk("wr_ready", {62'd0, bus_a.wr_ready, bus_b.wr_ready}, 64'd3);
  endtask
  task automatic cycle(bit v, logic [31:0] a, logic [63:0] d);
    drive(v, a, d);
    @(negedge clock);
    model(v, a, d);
    check_now();
  endtask
  task automatic noise();
    cycle(1'($urandom), TH + 32'(8 * $urandom_range(1, 4)), {$urandom, $urandom});
  endtask
  // Reset is dropped mid-cycle with the clock low, so clearing must be asynchronous.
  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_succ%0d", i), 64'(succ[i]), 64'd0);
      chk($sformatf("rst_fail%0d", i), 64'(fail[i]), 64'd0);
      chk($sformatf("rst_code%0d", i), 64'(code[i]), 64'd0);
      chk($sformatf("rst_reason%0d", i), 64'(reason[i]), 64'd0);
      chk($sformatf("rst_busy%0d", i), 64'(busy[i]), 64'd1);
      m_vat[i] = 0; m_kick[i] = 0; m_code[i] = '0; m_reason[i] = '0;
      sb[i].delete();
    end
    @(negedge clock);
    reset = 1'b1;
  endtask
  initial begin
    int n, r;
    drive(0, '0, '0);
    do_reset();
    repeat (9) noise();
    cycle(1, TH, 64'h1);
    repeat (25) begin
      if ($urandom_range(0, 3) == 0) cycle(1, TH, {$urandom, $urandom});
      else noise();
    end
    do_reset();
    repeat (4) noise();
    cycle(1, TH, 64'h55);
    repeat (25) noise();
    cycle(1, TH, 64'h1);
    repeat (3) noise();
    do_reset();
    repeat (2) noise();
    cycle(1, TH, 64'h3);
    repeat (5) noise();
    do_reset();
    cycle(1, TH, 64'h3);
    repeat (25) noise();
    do_reset();
    for (int k = 0; k < 300; k++) begin
      if (k % 50 == 49) cycle(1, TH, 64'h2);
      else noise();
    end
    repeat (110) noise();
    do_reset();
    repeat (99) noise();
    cycle(1, TH, 64'h1);
    repeat (20) noise();
    repeat (6) begin
      do_reset();
      n = $urandom_range(20, 160);
      repeat (n) begin
        r = $urandom_range(0, 99);
        if (r < 2) cycle(1, TH, r == 0 ? 64'h1 : {$urandom, 31'($urandom_range(0, 7)), 1'b1});
        else if (r < 12) cycle(1, TH, {$urandom, $urandom} & ~64'h1);
        else noise();
      end
      repeat (20) noise();
    end
    chk("sb_empty0", 64'(sb[0].size()), 64'd0);
    chk("sb_empty1", 64'(sb[1].size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
